mul_sched_rr: RTL

Round-robin scheduler that shares one 32-bit signed, 2-stage pipelined Booth multiplier between NUM_REQ requesters. Each requester has a valid/ready request channel and a valid/ready response channel. The block tracks in-flight operations by requester tag, captures the multiplier output into per-requester response FIFOs, and issues at most one operation per cycle. Its credit scheme guarantees every issued result has a FIFO slot, because the multiplier pipeline cannot stall. It sits between the execute-stage ports and the external multiplier instance.

---
 rtl/mul_sched_pkg.sv | 13 +
 rtl/booth_multiplier_32bit_pipeline.sv | 33 +++
 rtl/mul_rsp_fifo.sv | 55 +++++
 rtl/mul_sched_rr.sv | 124 ++++++++++++
 4 files changed

// File: rtl/mul_sched_pkg.sv
// Shared constants and types for the round-robin multiplier scheduler.
package mul_sched_pkg;
    localparam int DATA_W      = 32;
    localparam int MUL_LAT_DEF = 1;
    localparam int MAX_REQ     = 4;
    // Sized for the largest supported requester count so the tag type is fixed.
    localparam int REQ_ID_W    = $clog2(MAX_REQ);

    typedef struct packed {
        logic                valid;
        logic [REQ_ID_W-1:0] req_id;
    } tag_t;
endpackage

// File: rtl/booth_multiplier_32bit_pipeline.sv
// Two-stage signed multiplier: operands are registered, then a radix-2 Booth
// array forms the low 32 bits of the product from the registered operands.
module booth_multiplier_32bit_pipeline (
    input  logic        clk,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] product
);
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [32:0] b_ext;
    logic [31:0] acc;

    always_ff @(posedge clk) begin
        a_q <= a;
        b_q <= b;
    end

    assign b_ext = {b_q, 1'b0};

    always_comb begin
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            case (b_ext[i +: 2])
                2'b01:   acc = acc + (a_q << i);
                2'b10:   acc = acc - (a_q << i);
                default: ;
            endcase
        end
    end

    assign product = acc;
endmodule

// File: rtl/mul_rsp_fifo.sv
// Synchronous response FIFO; head shows the oldest entry whenever not empty.
module mul_rsp_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/mul_sched_rr.sv
// Round-robin scheduler sharing one non-stallable multiplier among NUM_REQ
// requesters; credits guarantee every issued product has a response slot.
module mul_sched_rr
    import mul_sched_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int MUL_LAT   = MUL_LAT_DEF,
    parameter int RSP_DEPTH = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [NUM_REQ*DATA_W-1:0] rsp_data,
    output logic [DATA_W-1:0]         mul_a,
    output logic [DATA_W-1:0]         mul_b,
    input  logic [DATA_W-1:0]         mul_out,
    output logic                      busy
);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    logic [CNT_W-1:0]    cnt [NUM_REQ];
    logic [REQ_ID_W-1:0] rr_ptr;
    tag_t                tag_pipe [MUL_LAT];
    tag_t                tag_head;
    logic [NUM_REQ-1:0]  elig;
    logic [NUM_REQ-1:0]  grant;
    logic [NUM_REQ-1:0]  push;
    logic [NUM_REQ-1:0]  pop;
    logic [NUM_REQ-1:0]  fifo_full;
    logic [NUM_REQ-1:0]  fifo_empty;
    logic [DATA_W-1:0]   fifo_head [NUM_REQ];
    logic [REQ_ID_W-1:0] grant_id;
    logic                grant_any;

    // Eligibility looks only at registered credits, so rsp_ready never reaches req_ready.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = rst_n && req_valid[i] && (cnt[i] < CNT_W'(RSP_DEPTH));
        end
    end

    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!grant_any && elig[(int'(rr_ptr) + k) % NUM_REQ]) begin
                grant_any = 1'b1;
                grant[(int'(rr_ptr) + k) % NUM_REQ] = 1'b1;
                grant_id  = REQ_ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign req_ready = grant;
    assign mul_a     = grant_any ? req_a[int'(grant_id)*DATA_W +: DATA_W] : '0;
    assign mul_b     = grant_any ? req_b[int'(grant_id)*DATA_W +: DATA_W] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= REQ_ID_W'(NUM_REQ - 1);
        end else if (grant_any) begin
            rr_ptr <= grant_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                case ({grant[i], pop[i]})
                    2'b10:   cnt[i] <= cnt[i] + CNT_W'(1);
                    2'b01:   cnt[i] <= cnt[i] - CNT_W'(1);
                    default: ;
                endcase
            end
        end
    end

    // Tags shadow the multiplier pipeline; clearing them drops any stale mul_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < MUL_LAT; s++) tag_pipe[s] <= '0;
        end else begin
            tag_pipe[0] <= '{valid: grant_any, req_id: grant_id};
            for (int s = 1; s < MUL_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
        end
    end

    assign tag_head = tag_pipe[MUL_LAT-1];

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) busy = busy | (cnt[i] != '0);
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp
        assign push[g]      = tag_head.valid && (tag_head.req_id == REQ_ID_W'(g)) && !fifo_full[g];
        assign pop[g]       = rsp_valid[g] && rsp_ready[g];
        assign rsp_valid[g] = !fifo_empty[g];
        assign rsp_data[g*DATA_W +: DATA_W] = fifo_empty[g] ? '0 : fifo_head[g];

        mul_rsp_fifo #(
            .DEPTH (RSP_DEPTH),
            .WIDTH (DATA_W)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push[g]),
            .push_data (mul_out),
            .pop       (pop[g]),
            .full      (fifo_full[g]),
            .empty     (fifo_empty[g]),
            .head      (fifo_head[g])
        );
    end
endmodule
